// File: rtl/audio_pkg.sv
// Shared types and constants for the audio playout path: sample width,
// midscale value, playout state encoding and the sample-rate divider
// for the 27 MHz system clock.
package audio_pkg;

    localparam int SAMPLE_W = 16;

    // Signed two's-complement midscale; becomes 0x8000 in offset binary,
    // which the modulator turns into a 50% ones density.
    localparam logic [SAMPLE_W-1:0] MIDSCALE = 16'h0000;

    // 27 MHz / 44.1 kHz, truncated.
    localparam int SAMPLE_DIV_27M = 612;

    typedef enum logic {
        ST_PREFILL = 1'b0,
        ST_PLAY    = 1'b1
    } playState_t;

    // Flipping the sign bit maps -32768..32767 onto 0..65535.
    function automatic logic [SAMPLE_W-1:0] toOffsetBinary(input logic [SAMPLE_W-1:0] s);
        return {~s[SAMPLE_W-1], s[SAMPLE_W-2:0]};
    endfunction

endpackage

// File: rtl/audio_playout_sync_fifo.sv
// Single-clock show-ahead FIFO. The head entry is always presented on
// rd_data; full/empty are derived from an occupancy counter, and the
// pointers simply wrap modulo the depth. A write is accepted while full
// when a read in the same cycle frees the slot.
module sync_fifo
    import audio_pkg::*;
#(
    parameter int W      = SAMPLE_W,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [W-1:0]      wr_data,
    input  logic              rd_en,
    output logic [W-1:0]      rd_data,
    output logic [ADDR_W:0]   level,
    output logic              full,
    output logic              empty
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] FULL_LEVEL = {1'b1, {ADDR_W{1'b0}}};

    logic [W-1:0]      r_mem [DEPTH];
    logic [ADDR_W-1:0] r_wrPtr;
    logic [ADDR_W-1:0] r_rdPtr;
    logic [ADDR_W:0]   r_level;
    logic              w_doRead;
    logic              w_doWrite;

    assign full    = (r_level == FULL_LEVEL);
    assign empty   = (r_level == '0);
    assign level   = r_level;
    assign rd_data = r_mem[r_rdPtr];

    assign w_doRead  = rd_en && !empty;
    assign w_doWrite = wr_en && (!full || w_doRead);

    // Storage array; left unreset so it can map onto RAM, the pointers make stale data unreachable.
    always_ff @(posedge clk) begin
        if (w_doWrite) begin
            r_mem[r_wrPtr] <= wr_data;
        end
    end

    // Pointer and occupancy bookkeeping; a simultaneous read and write leaves the level unchanged.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_level <= '0;
        end else begin
            if (w_doWrite) begin
                r_wrPtr <= r_wrPtr + ADDR_W'(1);
            end
            if (w_doRead) begin
                r_rdPtr <= r_rdPtr + ADDR_W'(1);
            end
            case ({w_doWrite, w_doRead})
                2'b10:   r_level <= r_level + (ADDR_W + 1)'(1);
                2'b01:   r_level <= r_level - (ADDR_W + 1)'(1);
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

// File: rtl/audio_playout.sv
// Playout stage behind the UART sample receiver: buffers incoming samples,
// releases one per sample-rate tick once enough have been prefilled, and
// renders the current sample as a first-order sigma-delta bitstream for an
// external RC low-pass. Sticky flags report dropped samples and starvation.
module audio_playout
    import audio_pkg::*;
#(
    parameter int ADDR_W     = 6,
    parameter int SAMPLE_DIV = SAMPLE_DIV_27M,
    parameter int PREFILL    = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [SAMPLE_W-1:0] in_sample,
    input  logic                in_valid,
    input  logic                clear_flags,
    output logic                audio_out,
    output logic                playing,
    output logic [ADDR_W:0]     level,
    output logic                overflow,
    output logic                underrun
);

    localparam int CNT_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam logic [CNT_W-1:0]  TICK_LAST     = CNT_W'(SAMPLE_DIV - 1);
    localparam logic [ADDR_W:0]   PREFILL_LEVEL = (ADDR_W + 1)'(PREFILL);

    logic [CNT_W-1:0]    r_tickCnt;
    logic                w_tick;

    playState_t          r_state;
    playState_t          w_stateNext;
    logic [SAMPLE_W-1:0] r_curSample;
    logic [SAMPLE_W-1:0] w_curSampleNext;
    logic                w_pop;
    logic                w_setUnderrun;
    logic                w_setOverflow;

    logic                r_overflow;
    logic                r_underrun;
    logic [SAMPLE_W:0]   r_acc;
    logic                r_audio;

    logic [SAMPLE_W-1:0] w_fifoHead;
    logic [ADDR_W:0]     w_fifoLevel;
    logic                w_fifoFull;
    logic                w_fifoEmpty;

    sync_fifo #(
        .W      (SAMPLE_W),
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (in_valid),
        .wr_data (in_sample),
        .rd_en   (w_pop),
        .rd_data (w_fifoHead),
        .level   (w_fifoLevel),
        .full    (w_fifoFull),
        .empty   (w_fifoEmpty)
    );

    assign w_tick        = (r_tickCnt == TICK_LAST);
    assign w_setOverflow = in_valid && w_fifoFull && !w_pop;

    assign audio_out = r_audio;
    assign playing   = (r_state == ST_PLAY);
    assign level     = w_fifoLevel;
    assign overflow  = r_overflow;
    assign underrun  = r_underrun;

    // Free-running sample-rate divider, independent of the playout state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tickCnt <= '0;
        end else if (w_tick) begin
            r_tickCnt <= '0;
        end else begin
            r_tickCnt <= r_tickCnt + CNT_W'(1);
        end
    end

    // Playout decision: hold midscale while prefilling, pop on ticks while playing, fall back on starvation.
    always_comb begin
        w_stateNext     = r_state;
        w_curSampleNext = r_curSample;
        w_pop           = 1'b0;
        w_setUnderrun   = 1'b0;
        case (r_state)
            ST_PREFILL: begin
                w_curSampleNext = MIDSCALE;
                if (w_fifoLevel >= PREFILL_LEVEL) begin
                    w_stateNext = ST_PLAY;
                end
            end
            ST_PLAY: begin
                if (w_tick) begin
                    if (!w_fifoEmpty) begin
                        w_pop           = 1'b1;
                        w_curSampleNext = w_fifoHead;
                    end else begin
                        w_setUnderrun   = 1'b1;
                        w_curSampleNext = MIDSCALE;
                        w_stateNext     = ST_PREFILL;
                    end
                end
            end
            default: begin
                w_stateNext     = ST_PREFILL;
                w_curSampleNext = MIDSCALE;
            end
        endcase
    end

    // Playout state and the sample currently being rendered.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_PREFILL;
            r_curSample <= MIDSCALE;
        end else begin
            r_state     <= w_stateNext;
            r_curSample <= w_curSampleNext;
        end
    end

    // Sticky status flags; a new event in the same cycle as a clear keeps the flag set.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_overflow <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            if (w_setOverflow) begin
                r_overflow <= 1'b1;
            end else if (clear_flags) begin
                r_overflow <= 1'b0;
            end
            if (w_setUnderrun) begin
                r_underrun <= 1'b1;
            end else if (clear_flags) begin
                r_underrun <= 1'b0;
            end
        end
    end

    // First-order sigma-delta: the carry out of a 16-bit phase accumulator is the output bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc   <= '0;
            r_audio <= 1'b0;
        end else begin
            r_acc   <= {1'b0, r_acc[SAMPLE_W-1:0]} + {1'b0, toOffsetBinary(r_curSample)};
            r_audio <= r_acc[SAMPLE_W];
        end
    end

endmodule

// File: tb/tb_audio_playout.sv
// Bench for audio_playout: a short hand-derived vector table, directed
// sequences for prefill order, underrun, overflow, full push/pop and
// modulator density, then randomized traffic checked every cycle against
// a queue-and-running-sum reference model.
module tb_audio_playout;

    localparam int ADDR_W = 6;
    localparam int DEPTH  = 64;
    localparam int DIV    = 40;
    localparam int PRE    = 32;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [15:0]       in_sample = '0;
    logic              in_valid = 1'b0;
    logic              clear_flags = 1'b0;
    logic              audio_out;
    logic              playing;
    logic [ADDR_W:0]   level;
    logic              overflow;
    logic              underrun;

    int total = 0;
    int bad   = 0;

    audio_playout #(
        .ADDR_W     (ADDR_W),
        .SAMPLE_DIV (DIV),
        .PREFILL    (PRE)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_sample   (in_sample),
        .in_valid    (in_valid),
        .clear_flags (clear_flags),
        .audio_out   (audio_out),
        .playing     (playing),
        .level       (level),
        .overflow    (overflow),
        .underrun    (underrun)
    );

    always #5 clk = ~clk;

    // Reference model: FIFO as a queue, modulator as a running sum whose
    // 65536-multiples crossings are the emitted ones.
    logic [15:0] mQ[$];
    bit          mPlay;
    int          mCnt;
    logic [15:0] mCur;
    bit          mOvf, mUnd, mAudio, mCarry, mTick;
    longint      mSum;

    typedef struct {
        bit              r;
        bit              v;
        logic [15:0]     s;
        bit              c;
        logic [ADDR_W:0] eLevel;
        bit              ePlay;
        bit              eOvf;
        bit              eUnd;
        bit              eAudio;
    } vec_t;

    vec_t vecs[13];

    task automatic checkOutput(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic modelEdge();
        bit     tick, pop, setOvf, setUnd;
        int     lvl;
        longint u, newSum;
        if (rst) begin
            mQ.delete();
            mPlay = 0; mCnt = 0; mCur = '0; mOvf = 0; mUnd = 0;
            mSum = 0; mCarry = 0; mAudio = 0; mTick = 0;
            return;
        end
        tick = (mCnt == DIV - 1);
        mCnt = tick ? 0 : mCnt + 1;
        u = longint'($signed(mCur)) + 32768;
        newSum = mSum + u;
        mAudio = mCarry;
        mCarry = ((newSum / 65536) != (mSum / 65536));
        mSum = newSum;
        lvl = mQ.size();
        pop = 0; setOvf = 0; setUnd = 0;
        if (!mPlay) begin
            mCur = '0;
            if (lvl >= PRE) mPlay = 1;
        end else if (tick) begin
            if (lvl > 0) begin
                pop = 1;
                mCur = mQ.pop_front();
            end else begin
                setUnd = 1;
                mCur = '0;
                mPlay = 0;
            end
        end
        if (in_valid) begin
            if (lvl < DEPTH || pop) mQ.push_back(in_sample);
            else setOvf = 1;
        end
        if (clear_flags) begin
            mOvf = 0;
            mUnd = 0;
        end
        if (setOvf) mOvf = 1;
        if (setUnd) mUnd = 1;
        mTick = tick;
    endtask

    task automatic applyStimulus(input bit r, input bit v, input logic [15:0] s, input bit c);
        rst = r; in_valid = v; in_sample = s; clear_flags = c;
        @(posedge clk);
        modelEdge();
        #1;
        checkOutput("cycle",
                    {audio_out, playing, level, overflow, underrun, dut.r_curSample},
                    {mAudio, mPlay, 7'(mQ.size()), mOvf, mUnd, mCur});
    endtask

    task automatic idle();
        applyStimulus(0, 0, 16'h0, 0);
    endtask

    task automatic doReset();
        for (int n = 0; n < 3; n++) applyStimulus(1, 0, 16'h0, 0);
    endtask

    task automatic waitTick();
        for (int n = 0; n < DIV + 2; n++) begin
            idle();
            if (mTick) return;
        end
        checkOutput("tick_timeout", 0, 1);
    endtask

    initial begin
        int ones;
        bit reached;
        int rate;
        logic [15:0] pattern [4];

        // ---- vector table: reset, pushes, clears, reset mid-stream ----
        vecs[0]  = '{1, 0, 16'h0000, 0, 7'd0, 0, 0, 0, 0};
        vecs[1]  = '{1, 0, 16'h0000, 0, 7'd0, 0, 0, 0, 0};
        vecs[2]  = '{1, 0, 16'h0000, 0, 7'd0, 0, 0, 0, 0};
        vecs[3]  = '{0, 1, 16'h1234, 0, 7'd1, 0, 0, 0, 0};
        vecs[4]  = '{0, 1, 16'h8000, 0, 7'd2, 0, 0, 0, 0};
        vecs[5]  = '{0, 0, 16'h0000, 1, 7'd2, 0, 0, 0, 1};
        vecs[6]  = '{0, 1, 16'h7FFF, 0, 7'd3, 0, 0, 0, 0};
        vecs[7]  = '{0, 1, 16'h0001, 1, 7'd4, 0, 0, 0, 1};
        vecs[8]  = '{1, 1, 16'hABCD, 0, 7'd0, 0, 0, 0, 0};
        vecs[9]  = '{0, 0, 16'h0000, 0, 7'd0, 0, 0, 0, 0};
        vecs[10] = '{0, 1, 16'h0042, 0, 7'd1, 0, 0, 0, 0};
        vecs[11] = '{0, 1, 16'hFFFF, 0, 7'd2, 0, 0, 0, 1};
        vecs[12] = '{0, 0, 16'h0000, 0, 7'd2, 0, 0, 0, 0};
        for (int i = 0; i < 13; i++) begin
            applyStimulus(vecs[i].r, vecs[i].v, vecs[i].s, vecs[i].c);
            checkOutput($sformatf("vec%0d", i),
                        {audio_out, playing, level, overflow, underrun},
                        {vecs[i].eAudio, vecs[i].ePlay, vecs[i].eLevel, vecs[i].eOvf, vecs[i].eUnd});
        end

        // ---- prefill, playout order, underrun, re-entry, reset mid-PLAY ----
        doReset();
        for (int i = 1; i <= 32; i++) applyStimulus(0, 1, 16'(i), 0);
        checkOutput("prefill_level", level, 32);
        checkOutput("prefill_playing", playing, 0);
        idle();
        checkOutput("play_start", playing, 1);
        for (int k = 1; k <= 32; k++) begin
            waitTick();
            checkOutput($sformatf("order%0d", k), dut.r_curSample, k);
        end
        checkOutput("drained_playing", playing, 1);
        waitTick();
        checkOutput("underrun_flag", underrun, 1);
        checkOutput("underrun_playing", playing, 0);
        checkOutput("underrun_cur", dut.r_curSample, 0);
        for (int i = 0; i < 32; i++) applyStimulus(0, 1, 16'(16'h0100 + i), 0);
        checkOutput("reprefill_playing", playing, 0);
        idle();
        checkOutput("replay_start", playing, 1);
        waitTick();
        checkOutput("replay_first", dut.r_curSample, 16'h0100);
        waitTick();
        checkOutput("replay_second", dut.r_curSample, 16'h0101);
        applyStimulus(1, 1, 16'h5555, 0);
        checkOutput("midplay_reset", {audio_out, playing, level, overflow, underrun}, 0);
        checkOutput("midplay_reset_cur", dut.r_curSample, 0);

        // ---- modulator density over 32-cycle windows inside one sample hold ----
        pattern[0] = 16'h8000; pattern[1] = 16'h0000; pattern[2] = 16'h4000; pattern[3] = 16'h7FFF;
        doReset();
        for (int i = 0; i < 32; i++) applyStimulus(0, 1, pattern[i % 4], 0);
        idle();
        for (int p = 0; p < 4; p++) begin
            waitTick();
            idle();
            idle();
            ones = 0;
            for (int n = 0; n < 32; n++) begin
                idle();
                ones += int'(audio_out);
            end
            case (p)
                0: checkOutput("density_8000", ones, 0);
                1: checkOutput("density_0000", ones, 16);
                2: checkOutput("density_4000", ones, 24);
                default: checkOutput("density_7fff_in_31_32", (ones == 31 || ones == 32), 1);
            endcase
        end

        // ---- overflow, set-beats-clear, clear, push+pop at full ----
        doReset();
        reached = 0;
        for (int n = 0; n < 400; n++) begin
            if (mQ.size() == DEPTH && mCnt != DIV - 1) begin
                reached = 1;
                break;
            end
            applyStimulus(0, 1, 16'(16'h2000 + n), 0);
        end
        if (!reached) checkOutput("fill_timeout", 0, 1);
        checkOutput("full_no_overflow_yet", overflow, 0);
        applyStimulus(0, 1, 16'hDEAD, 1);
        checkOutput("overflow_set_beats_clear", overflow, 1);
        checkOutput("overflow_level", level, 64);
        applyStimulus(0, 0, 16'h0, 1);
        checkOutput("overflow_cleared", overflow, 0);
        reached = 0;
        for (int n = 0; n < 400; n++) begin
            if (mQ.size() == DEPTH && mCnt == DIV - 1) begin
                reached = 1;
                break;
            end
            if (mQ.size() < DEPTH) applyStimulus(0, 1, 16'(16'h3000 + n), 0);
            else idle();
        end
        if (!reached) checkOutput("align_timeout", 0, 1);
        applyStimulus(0, 1, 16'hBEEF, 0);
        checkOutput("pushpop_full_level", level, 64);
        checkOutput("pushpop_full_overflow", overflow, 0);

        // ---- randomized traffic at several push rates ----
        doReset();
        for (int seg = 0; seg < 8; seg++) begin
            case (seg % 4)
                0: rate = 1;
                1: rate = 3;
                2: rate = 20;
                default: rate = 90;
            endcase
            for (int n = 0; n < 2000; n++) begin
                applyStimulus(($urandom_range(2999) == 0),
                              ($urandom_range(99) < rate),
                              16'($urandom),
                              ($urandom_range(49) == 0));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
